// File: rtl/fft_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_sched_pkg
// Description : Shared state encoding and channel-width helper for the
//               FFT frame scheduler.
// Revision    : 1.0
// ============================================================================
package fft_sched_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } sched_state_t;

    // Width of a channel index; a single requester still needs one bit.
    function automatic int ch_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sched_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sched_tag_fifo
// Description : Synchronous FIFO holding the source channel of each frame
//               in flight through the FFT. Head is visible without a pop.
// Revision    : 1.0
// ============================================================================
module sched_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic             w_do_push;
    logic             w_do_pop;

    assign full  = (r_occ == OCC_W'(DEPTH));
    assign empty = (r_occ == '0);
    assign head  = r_mem[r_rd_ptr];

    // A pop frees the head slot in the same cycle, so push-while-full is
    // accepted when paired with a pop.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_sched
// Description : Round-robin, frame-granular scheduler sharing one FFT among
//               NREQ requesters; labels FFT output frames with their source
//               channel. Optional clip attribution under FFT_SCHED_CLIP_EN.
// Revision    : 1.0
// ============================================================================
module fft_frame_sched
    import fft_sched_pkg::*;
#(
    parameter int IN_W      = 12,
    parameter int LEN       = 256,
    parameter int NREQ      = 4,
    parameter int TAG_DEPTH = 4,
    localparam int CH_W     = ch_width(NREQ)
) (
    input  logic                 mclk,
    input  logic                 i_init,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ-1:0]      i_s_vld,
    input  logic [NREQ*IN_W-1:0] i_s_I,
    input  logic [NREQ*IN_W-1:0] i_s_Q,
    output logic [NREQ-1:0]      o_s_rdy,
    output logic                 o_fft_init,
    output logic                 o_fft_vld,
    output logic [IN_W-1:0]      o_fft_I,
    output logic [IN_W-1:0]      o_fft_Q,
    input  logic                 i_fft_vld,
    input  logic                 i_fft_new,
    input  logic                 i_fft_clip,
    output logic                 o_vld,
    output logic [CH_W-1:0]      o_chan,
    output logic                 o_last,
    output logic [NREQ-1:0]      o_clip_flags,
    input  logic [NREQ-1:0]      i_clip_clr,
    output logic [7:0]           o_err_cnt
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [CH_W-1:0]  r_grant;
    logic [CH_W-1:0]  r_last_grant;
    logic [CH_W-1:0]  w_pick;
    logic             w_pick_vld;
    logic [CNT_W-1:0] r_in_cnt;
    logic             w_accept;
    logic             w_frame_done;
    logic             w_push;
    logic             r_fft_vld;
    logic [IN_W-1:0]  r_fft_I;
    logic [IN_W-1:0]  r_fft_Q;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CH_W-1:0]  w_head;
    logic             w_pop;
    logic [CNT_W-1:0] r_out_cnt;
    logic [CNT_W-1:0] w_out_idx;
    logic             w_out_last;
    logic             r_vld;
    logic             r_last;
    logic [CH_W-1:0]  r_chan;
    logic [7:0]       r_err_cnt;

    assign o_fft_init = i_init;
    assign o_fft_vld  = r_fft_vld;
    assign o_fft_I    = r_fft_I;
    assign o_fft_Q    = r_fft_Q;
    assign o_vld      = r_vld;
    assign o_last     = r_last;
    assign o_chan     = r_chan;
    assign o_err_cnt  = r_err_cnt;

    // Scan offsets downwards so the smallest offset after last_grant wins.
    always_comb begin : p_rr_pick
        logic [CH_W-1:0] v_idx;
        w_pick     = r_last_grant;
        w_pick_vld = 1'b0;
        v_idx      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            v_idx = CH_W'((int'(r_last_grant) + k) % NREQ);
            if (i_req[v_idx]) begin
                w_pick     = v_idx;
                w_pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (i_init) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_push       = 1'b0;
        w_accept     = 1'b0;
        w_frame_done = 1'b0;
        o_s_rdy      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld && !w_fifo_full) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                o_s_rdy[r_grant] = 1'b1;
                w_accept         = i_s_vld[r_grant];
                if (w_accept && (r_in_cnt == CNT_W'(LEN - 1))) begin
                    w_frame_done = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (i_init) begin
            r_grant      <= '0;
            r_last_grant <= CH_W'(NREQ - 1);
            r_in_cnt     <= '0;
            r_fft_vld    <= 1'b0;
            r_fft_I      <= '0;
            r_fft_Q      <= '0;
        end else begin
            r_fft_vld <= w_accept;
            if (w_push) begin
                r_grant <= w_pick;
            end
            if (w_accept) begin
                r_fft_I  <= i_s_I[int'(r_grant)*IN_W +: IN_W];
                r_fft_Q  <= i_s_Q[int'(r_grant)*IN_W +: IN_W];
                r_in_cnt <= w_frame_done ? '0 : r_in_cnt + CNT_W'(1);
            end
            if (w_frame_done) begin
                r_last_grant <= r_grant;
            end
        end
    end

    sched_tag_fifo #(
        .W     (CH_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (mclk),
        .rst       (i_init),
        .push      (w_push),
        .push_data (w_pick),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // A new-frame strobe restarts the sample index at zero for this sample.
    assign w_out_idx  = i_fft_new ? '0 : r_out_cnt;
    assign w_out_last = i_fft_vld && (w_out_idx == CNT_W'(LEN - 1));
    assign w_pop      = w_out_last && !w_fifo_empty;

    always_ff @(posedge mclk) begin
        if (i_init) begin
            r_vld     <= 1'b0;
            r_last    <= 1'b0;
            r_chan    <= '0;
            r_out_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            r_vld  <= i_fft_vld;
            r_last <= w_out_last;
            if (i_fft_vld) begin
                r_out_cnt <= w_out_idx + CNT_W'(1);
                if (i_fft_new) begin
                    if (!w_fifo_empty) begin
                        r_chan <= w_head;
                    end else if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
            end
        end
    end

`ifdef FFT_SCHED_CLIP_EN
    logic [NREQ-1:0] r_clip_flags;
    logic [NREQ-1:0] w_clip_set;

    always_comb begin
        w_clip_set = '0;
        if (i_fft_clip && !w_fifo_empty) begin
            w_clip_set[w_head] = 1'b1;
        end
    end

    // Clear is applied after set so it wins on the same cycle.
    always_ff @(posedge mclk) begin
        if (i_init) begin
            r_clip_flags <= '0;
        end else begin
            r_clip_flags <= (r_clip_flags | w_clip_set) & ~i_clip_clr;
        end
    end

    assign o_clip_flags = r_clip_flags;
`else
    logic w_unused_clip;
    assign w_unused_clip = ^{i_fft_clip, i_clip_clr};
    assign o_clip_flags  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sched.sv
`default_nettype none
// Self-checking bench for fft_frame_sched: directed scenarios plus random
// traffic, checked every cycle against a queue-based behavioural model.
module tb_fft_frame_sched;

    localparam int IN_W = 12;
    localparam int LEN  = 16;
    localparam int NREQ = 4;
    localparam int TDEP = 4;

    logic                 clk = 1'b0;
    logic                 init = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ-1:0]      s_vld = '0;
    logic [NREQ*IN_W-1:0] s_I = '0;
    logic [NREQ*IN_W-1:0] s_Q = '0;
    logic                 fft_vld = 1'b0;
    logic                 fft_new = 1'b0;
    logic                 clip = 1'b0;
    logic [NREQ-1:0]      clr = '0;
    logic [NREQ-1:0]      o_s_rdy;
    logic                 o_fft_init;
    logic                 o_fft_vld;
    logic [IN_W-1:0]      o_fft_I;
    logic [IN_W-1:0]      o_fft_Q;
    logic                 o_vld;
    logic [1:0]           o_chan;
    logic                 o_last;
    logic [NREQ-1:0]      o_clip_flags;
    logic [7:0]           o_err_cnt;

    fft_frame_sched #(.IN_W(IN_W), .LEN(LEN), .NREQ(NREQ), .TAG_DEPTH(TDEP)) dut (
        .mclk(clk), .i_init(init), .i_req(req), .i_s_vld(s_vld),
        .i_s_I(s_I), .i_s_Q(s_Q), .o_s_rdy(o_s_rdy), .o_fft_init(o_fft_init),
        .o_fft_vld(o_fft_vld), .o_fft_I(o_fft_I), .o_fft_Q(o_fft_Q),
        .i_fft_vld(fft_vld), .i_fft_new(fft_new), .i_fft_clip(clip),
        .o_vld(o_vld), .o_chan(o_chan), .o_last(o_last),
        .o_clip_flags(o_clip_flags), .i_clip_clr(clr), .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int              tagq[$];
    int              m_owner = -1;
    int              m_cnt = 0;
    int              m_last_grant = NREQ - 1;
    int              m_out_idx = 0;
    int              m_chan = 0;
    int              m_err = 0;
    bit              m_vld = 0;
    bit              m_last = 0;
    bit              m_fft_vld = 0;
    bit [IN_W-1:0]   m_fft_I = '0;
    bit [IN_W-1:0]   m_fft_Q = '0;
    bit [NREQ-1:0]   m_flags = '0;

    task automatic model_step();
        int  head;
        int  pick;
        int  idx;
        bit  push;
        bit  pop;
        head = -1; pick = 0; idx = 0; push = 0; pop = 0;
        if (init) begin
            tagq.delete();
            m_owner = -1; m_cnt = 0; m_last_grant = NREQ - 1; m_out_idx = 0;
            m_chan = 0; m_err = 0; m_vld = 0; m_last = 0; m_fft_vld = 0;
            m_fft_I = '0; m_fft_Q = '0; m_flags = '0;
            return;
        end
        if (tagq.size() > 0) head = tagq[0];
        m_fft_vld = 0;
        if (m_owner < 0) begin
            if (req != 0 && tagq.size() < TDEP) begin
                for (int k = 1; k <= NREQ; k++) begin
                    pick = (m_last_grant + k) % NREQ;
                    if (req[pick]) break;
                end
                m_owner = pick;
                push = 1;
            end
        end else if (s_vld[m_owner]) begin
            m_fft_vld = 1;
            m_fft_I = s_I[m_owner*IN_W +: IN_W];
            m_fft_Q = s_Q[m_owner*IN_W +: IN_W];
            m_cnt++;
            if (m_cnt == LEN) begin
                m_cnt = 0;
                m_last_grant = m_owner;
                m_owner = -1;
            end
        end
        m_vld = fft_vld;
        m_last = 0;
        if (fft_vld) begin
            idx = fft_new ? 0 : m_out_idx;
            if (fft_new) begin
                if (head >= 0) m_chan = head;
                else if (m_err < 255) m_err++;
            end
            if (idx == LEN - 1) begin
                m_last = 1;
                pop = (head >= 0);
            end
            m_out_idx = (idx + 1) % LEN;
        end
`ifdef FFT_SCHED_CLIP_EN
        if (clip && head >= 0) m_flags[head] = 1'b1;
        m_flags = m_flags & ~clr;
`endif
        if (pop) void'(tagq.pop_front());
        if (push) tagq.push_back(m_owner);
    endtask

    task automatic compare();
        logic [NREQ-1:0] er;
        er = '0;
        if (m_owner >= 0) er[m_owner] = 1'b1;
        chk("s_rdy", 64'(o_s_rdy), 64'(er));
        chk("fft_init", 64'(o_fft_init), 64'(init));
        chk("fft_vld", 64'(o_fft_vld), 64'(m_fft_vld));
        chk("fft_I", 64'(o_fft_I), 64'(m_fft_I));
        chk("fft_Q", 64'(o_fft_Q), 64'(m_fft_Q));
        chk("vld", 64'(o_vld), 64'(m_vld));
        chk("chan", 64'(o_chan), 64'(m_chan));
        chk("last", 64'(o_last), 64'(m_last));
        chk("clip_flags", 64'(o_clip_flags), 64'(m_flags));
        chk("err_cnt", 64'(o_err_cnt), 64'(m_err));
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        compare();
    end

    // ---------------- FFT stand-in and observation logs ----------------
    int lat = 0;
    bit flush = 0;
    bit gap = 0;
    bit ovr_new = 0;
    int e_in = 0;
    int e_pend = 0;
    int e_pos = -1;

    int cyc = 0;
    int grants[$];
    int grant_cyc[$];
    int lasts[$];
    int last_len[$];
    int last_cyc[$];
    int fvld_cnt = 0;
    int rdy_hi = 0;
    int frame_cnt = 0;
    logic [NREQ-1:0] prev_rdy = '0;

    task automatic env_update();
        fft_vld = 1'b0;
        fft_new = 1'b0;
        if (init) begin
            e_in = 0; e_pend = 0; e_pos = -1;
            return;
        end
        if (o_fft_vld === 1'b1) begin
            e_in++;
            if (e_in == LEN) begin
                e_in = 0;
                e_pend++;
            end
        end
        if (ovr_new) begin
            fft_vld = 1'b1;
            fft_new = 1'b1;
            return;
        end
        if (e_pos < 0 && (e_pend > lat || (flush && e_pend > 0))) begin
            e_pos = 0;
            e_pend--;
        end
        if (e_pos >= 0 && !(gap && $urandom_range(0, 3) == 0)) begin
            fft_vld = 1'b1;
            fft_new = (e_pos == 0);
            e_pos++;
            if (e_pos == LEN) e_pos = -1;
        end
    endtask

    task automatic clear_logs();
        grants.delete(); grant_cyc.delete(); lasts.delete();
        last_len.delete(); last_cyc.delete();
        fvld_cnt = 0; rdy_hi = 0; frame_cnt = 0;
    endtask

    task automatic tick();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        s_I = r[NREQ*IN_W-1:0];
        r = {$urandom(), $urandom()};
        s_Q = r[NREQ*IN_W-1:0];
        @(negedge clk);
        env_update();
        @(posedge clk);
        #2;
        cyc++;
        if (o_s_rdy != 0 && prev_rdy == 0) begin
            for (int i = 0; i < NREQ; i++) if (o_s_rdy[i]) grants.push_back(i);
            grant_cyc.push_back(cyc);
        end
        prev_rdy = o_s_rdy;
        if (o_s_rdy != 0) rdy_hi++;
        if (o_fft_vld) fvld_cnt++;
        if (o_vld) begin
            frame_cnt++;
            if (o_last) begin
                lasts.push_back(int'(o_chan));
                last_len.push_back(frame_cnt);
                last_cyc.push_back(cyc);
                frame_cnt = 0;
            end
        end
    endtask

    task automatic do_reset();
        init = 1'b1; req = '0; s_vld = '0; clip = 1'b0; clr = '0;
        flush = 0; gap = 0; ovr_new = 0;
        tick();
        tick();
        init = 1'b0;
        clear_logs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        // 1: alternating pair, continuous data
        do_reset();
        chk("reset_s_rdy", 64'(o_s_rdy), 64'h0);
        chk("reset_chan", 64'(o_chan), 64'h0);
        lat = 0; req = 4'b0101; s_vld = '1;
        for (int k = 0; k < 200 && grants.size() < 4; k++) tick();
        req = '0;
        for (int k = 0; k < 300 && lasts.size() < 4; k++) tick();
        chk("s1_ngrants", 64'(grants.size()), 64'd4);
        if (grants.size() >= 4) begin
            chk("s1_g0", 64'(grants[0]), 64'd0);
            chk("s1_g1", 64'(grants[1]), 64'd2);
            chk("s1_g2", 64'(grants[2]), 64'd0);
            chk("s1_g3", 64'(grants[3]), 64'd2);
            chk("s1_period", 64'(grant_cyc[1] - grant_cyc[0]), 64'd17);
        end
        chk("s1_fvld", 64'(fvld_cnt), 64'd64);
        chk("s1_nlast", 64'(lasts.size()), 64'd4);
        foreach (last_len[i]) chk("s1_len", 64'(last_len[i]), 64'd16);
        chk("s1_model_lg", 64'(m_last_grant), 64'd2);

        // 2: ch1 only, valid every other cycle
        do_reset();
        req = 4'b0010;
        ok = 0;
        for (int k = 0; k < 120; k++) begin
            s_vld = cyc[0] ? 4'b0010 : 4'b0000;
            tick();
            if (grants.size() > 0 && o_s_rdy == 0) begin ok = 1; break; end
        end
        chk("s2_done", 64'(ok), 64'd1);
        chk("s2_grant", 64'(grants.size() > 0 ? grants[0] : -1), 64'd1);
        chk("s2_fvld", 64'(fvld_cnt), 64'd16);
        chk("s2_span", 64'(rdy_hi >= 31 && rdy_hi <= 32), 64'd1);

        // 3: FFT with three frames of latency, all channels requesting
        do_reset();
        lat = 3; req = '1; s_vld = '1;
        for (int k = 0; k < 400 && grants.size() < 5; k++) tick();
        req = '0;
        chk("s3_ngrants", 64'(grants.size()), 64'd5);
        if (grants.size() >= 5 && last_cyc.size() >= 1) begin
            for (int i = 0; i < 5; i++) chk("s3_grant", 64'(grants[i]), 64'(i % 4));
            chk("s3_stall", 64'(grant_cyc[4] - last_cyc[0]), 64'd1);
        end
        flush = 1;
        for (int k = 0; k < 600 && lasts.size() < 5; k++) tick();
        chk("s3_nlast", 64'(lasts.size()), 64'd5);
        if (lasts.size() >= 5)
            for (int i = 0; i < 5; i++) chk("s3_chan", 64'(lasts[i]), 64'(i % 4));
        foreach (last_len[i]) chk("s3_len", 64'(last_len[i]), 64'd16);

        // 4: reset in the middle of a ch3 frame
        do_reset();
        lat = 0; req = 4'b1000; s_vld = '1;
        for (int k = 0; k < 100 && fvld_cnt < 7; k++) tick();
        chk("s4_reached7", 64'(fvld_cnt), 64'd7);
        init = 1'b1;
        #1;
        chk("s4_fft_init", 64'(o_fft_init), 64'd1);
        tick();
        chk("s4_rdy", 64'(o_s_rdy), 64'h0);
        chk("s4_fvld", 64'(o_fft_vld), 64'h0);
        chk("s4_fI", 64'(o_fft_I), 64'h0);
        chk("s4_vld_last", 64'({o_vld, o_last}), 64'h0);
        chk("s4_model_q", 64'(tagq.size()), 64'd0);
        init = 1'b0;
        req = '0;
        ovr_new = 1;
        tick();
        ovr_new = 0;
        chk("s4_err", 64'(o_err_cnt), 64'd1);
        chk("s4_chan", 64'(o_chan), 64'd0);
        clear_logs();
        req = '1;
        for (int k = 0; k < 20 && grants.size() < 1; k++) tick();
        chk("s4_next", 64'(grants.size() > 0 ? grants[0] : -1), 64'd0);

        // 5/6: clip attribution to the ch2 frame at the FIFO head
        do_reset();
        lat = 3; req = 4'b0100; s_vld = '1;
        for (int k = 0; k < 20 && grants.size() < 1; k++) tick();
        req = '0;
        clip = 1'b1; clr = 4'b0100;
        tick();
        clip = 1'b0; clr = '0;
        tick();
        chk("s5_clr_wins", 64'(o_clip_flags), 64'h0);
        clip = 1'b1;
        tick();
        clip = 1'b0;
        tick();
`ifdef FFT_SCHED_CLIP_EN
        chk("s5_flag", 64'(o_clip_flags), 64'h4);
`else
        chk("s6_flag", 64'(o_clip_flags), 64'h0);
`endif

        // random traffic
        do_reset();
        gap = 1;
        lat = $urandom_range(0, 3);
        req = 4'($urandom());
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 19) == 0) req = 4'($urandom());
            s_vld = 4'($urandom()) | 4'($urandom());
            clip = ($urandom_range(0, 19) == 0);
            clr = ($urandom_range(0, 29) == 0) ? 4'($urandom()) : 4'h0;
            ovr_new = ($urandom_range(0, 399) == 0);
            init = ($urandom_range(0, 499) == 0);
            if (init) lat = $urandom_range(0, 3);
            tick();
        end
        init = 1'b0; ovr_new = 0; clip = 1'b0; clr = '0;
        req = '0; s_vld = '1; flush = 1; gap = 0;
        for (int k = 0; k < 600; k++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_frame_sched.md
# fft_frame_sched

Frame-granular scheduler that shares one `fft` pipeline between `NREQ` sample requesters. It grants the pipeline round-robin, one whole frame of `LEN` samples at a time, and drives the FFT input port. It tracks in-flight frames in a tag FIFO so each output frame from the FFT is labelled with its source channel and framed with a last strobe. It sits directly in front of, and wraps the handshake of, the `fft` instance.

## Interface
- `IN_W`, 12, sample width per I/Q component; must match the FFT `IN_W`.
- `LEN`, 256, FFT frame length in samples; power of two.
- `NREQ`, 4, number of requesters, 2..16.
- `TAG_DEPTH`, 4, maximum frames in flight (tag FIFO depth); power of two.
- `mclk`  in  1  clock.
- `i_init`  in  1  synchronous active-high reset.
- `i_req`  in  NREQ  per-channel request: channel has a frame to send.
- `i_s_vld`  in  NREQ  per-channel sample valid.
- `i_s_I`, `i_s_Q`  in  NREQ*IN_W  packed samples; channel k occupies bits [k*IN_W +: IN_W].
- `o_s_rdy`  out  NREQ  one-hot; set only for the channel currently granted.
- `o_fft_init`  out  1  drives FFT `i_init`.
- `o_fft_vld`  out  1  drives FFT `i_vld`.
- `o_fft_I`, `o_fft_Q`  out  IN_W  drive FFT `i_I` and `i_Q`.
- `i_fft_vld`, `i_fft_new`, `i_fft_clip`  in  1  FFT `o_vld`, `o_new_fft`, `o_clip_strb`.
- `o_vld`  out  1  copy of `i_fft_vld`.
- `o_chan`  out  $clog2(NREQ)  source channel of the current output sample.
- `o_last`  out  1  final (LEN-th) output sample of a frame.
- `o_clip_flags`  out  NREQ  sticky per-channel clip flags.
- `i_clip_clr`  in  NREQ  clears `o_clip_flags` bits; a clear has priority over a same-cycle set.

## Operation
States: IDLE, STREAM.

**IDLE**
- Entered when any `i_req` bit is set and the tag FIFO is not full.
- Pick the first requesting channel at or after `last_grant+1`, modulo NREQ.
- Push the chosen channel onto the tag FIFO, set `o_s_rdy`, and go to STREAM.

**STREAM**
- Each cycle where the granted channel has `i_s_vld` set, forward its sample to the FFT and increment the input counter.
- Gaps in `i_s_vld` are allowed. The FFT tolerates invalid cycles.
- When the counter reaches LEN-1 and the sample is valid: clear `o_s_rdy`, reset the counter, record `last_grant`, and go to IDLE.
- Dropping `i_req` mid-frame does not end the frame. The grant holds until LEN samples are accepted.

**Output side**
- On `i_fft_vld` together with `i_fft_new`, latch the tag FIFO head into `o_chan` and reset the output counter.
- On `i_fft_vld` with output count equal to LEN-1, assert `o_last` and pop the tag FIFO.

**Simultaneous events and limits**
- A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- `i_fft_new` with an empty tag FIFO is an error. `o_chan` holds its value and the sticky error counter `err_cnt` increments.

**Clip attribution**
- `i_fft_clip` sets `o_clip_flags` for the channel at the tag FIFO head, i.e. the oldest in-flight frame.
- With an empty FIFO, the strobe is ignored.

**Reset**
- `i_init` forces IDLE and empties the tag FIFO.
- Counters are cleared, `last_grant` is set to NREQ-1 so that channel 0 wins first, and `o_clip_flags` is cleared.
- A frame in progress is discarded. `o_fft_init` equals `i_init` (combinational pass-through), so the FFT is flushed in the same cycle.

## Timing
- Reset values: `o_s_rdy`=0, `o_fft_vld`=0, `o_fft_I`/`o_fft_Q`=0, `o_chan`=0, `o_last`=0, `o_clip_flags`=0.
- Grant latency: `i_req` sampled in IDLE at cycle t; `o_s_rdy` is high at t+1.
- Sample path is registered: a valid sample at t appears on `o_fft_vld`/`o_fft_I`/`o_fft_Q` at t+1.
- Frame turnaround: the last sample at cycle t is followed by IDLE at t+1 and the next `o_s_rdy` at t+2. This gives at most 1 bubble between frames.
- Output path is registered: `o_vld`, `o_chan` and `o_last` lag `i_fft_vld` by 1 cycle.
- Backpressure: with the tag FIFO full, IDLE waits. Requesters see `o_s_rdy`=0 indefinitely.

## Configuration
- `FFT_SCHED_CLIP_EN` defined: clip attribution logic, `o_clip_flags` and `i_clip_clr` behave as specified.
- Undefined: `o_clip_flags` is tied to 0; `i_fft_clip` and `i_clip_clr` are ignored; no clip registers are synthesised.

## Structure
- Shared package `fft_sched_pkg`:
  - state encodings `ST_IDLE`, `ST_STREAM`;
  - the function that derives `CH_W = $clog2(NREQ)`.
- One sub-module, `sched_tag_fifo`: a CH_W-wide synchronous FIFO of depth TAG_DEPTH.
  - Ports: push, pop, head, full, empty.
  - Occupancy counter is $clog2(TAG_DEPTH)+1 bits.
- Round-robin priority pick stays inline.

## Test plan
Bench configuration: LEN=16, NREQ=4, TAG_DEPTH=4.

1. `i_req`=4'b0101 held, continuous valid data. Grants go ch0, ch2, ch0, ch2; each frame gives exactly 16 `o_fft_vld` pulses; 1 bubble between frames.
2. Ch1 only, `i_s_vld` toggling every other cycle. The frame completes after 16 valid samples (32 cycles); gaps are not counted.
3. The FFT is replaced by a model with 3 frames of latency, and all 4 channels request. The 5th grant stalls until the first `o_last`. `o_chan` sequence is 0, 1, 2, 3, 0, each `o_last` on sample 16.
4. Assert `i_init` at sample 7 of a ch3 frame. Next cycle: all outputs are at reset values, FIFO is empty, and `o_fft_init` is high in the same cycle. The next grant goes to ch0.
5. With `FFT_SCHED_CLIP_EN` defined, pulse `i_fft_clip` while the ch2 frame is at the FIFO head, with `i_clip_clr[2]` asserted the same cycle. Flag stays 0. Repeat without the clear: `o_clip_flags`=4'b0100.
6. Without `FFT_SCHED_CLIP_EN`: repeat scenario 5. `o_clip_flags` stays 0.
